// File: rtl/constant_pkg.sv
// Shared register-file write encodings and the writeback request record
// used by the writeback unit and its collision FIFO.
package constant;

   localparam logic [1:0] RW_NONE = 2'b00;
   localparam logic [1:0] RW_GPR  = 2'b01;
   localparam logic [1:0] RW_FPR  = 2'b10;

   typedef struct packed {
      logic [1:0]  rw;
      logic [4:0]  rd;
      logic [31:0] data;
   } wb_req_t;

   // Scoreboard slot for a destination: FPRs live in the upper half
   function automatic logic [5:0] sb_index(input logic [1:0] rw, input logic [4:0] rd);
      return {rw == RW_FPR, rd};
   endfunction

endpackage

// File: rtl/writeback_unit_fifo.sv
// Collision FIFO of writeback requests: two ordered push ports, one pop.
// Pushes that do not fit are dropped and flagged through overflow.
module wb_fifo
   import constant::*;
#(
   parameter int DEPTH = 4
) (
   input  logic                       clk,
   input  logic                       rstn,
   input  logic                       push0_valid,
   input  wb_req_t                    push0_data,
   input  logic                       push1_valid,
   input  wb_req_t                    push1_data,
   input  logic                       pop,
   output logic [$clog2(DEPTH):0]     count,
   output wb_req_t                    head,
   output logic                       overflow
);

   localparam int PTR_W = $clog2(DEPTH);

   wb_req_t            mem [DEPTH];
   logic [PTR_W-1:0]   rd_ptr;
   logic [PTR_W-1:0]   wr_ptr;
   logic [PTR_W-1:0]   wr_ptr_b;
   logic [PTR_W:0]     cnt;
   logic [PTR_W:0]     space;
   logic [PTR_W:0]     space_after0;
   logic               do_pop;
   logic               accept0;
   logic               accept1;

   // Space counts the slot freed by this cycle's pop; push0 always goes first
   always_comb begin
      do_pop       = pop && (cnt != '0);
      space        = (PTR_W+1)'(DEPTH) - cnt + (PTR_W+1)'(do_pop);
      accept0      = push0_valid && (space != '0);
      space_after0 = space - (PTR_W+1)'(accept0);
      accept1      = push1_valid && (space_after0 != '0);
      overflow     = (push0_valid && !accept0) || (push1_valid && !accept1);
      wr_ptr_b     = wr_ptr + PTR_W'(accept0);
   end

   always_ff @(posedge clk or negedge rstn) begin
      if (!rstn) begin
         cnt    <= '0;
         rd_ptr <= '0;
         wr_ptr <= '0;
      end else begin
         cnt    <= cnt + (PTR_W+1)'(accept0) + (PTR_W+1)'(accept1) - (PTR_W+1)'(do_pop);
         wr_ptr <= wr_ptr + PTR_W'(accept0) + PTR_W'(accept1);
         rd_ptr <= rd_ptr + PTR_W'(do_pop);
      end
   end

   always_ff @(posedge clk) begin
      if (accept0) mem[wr_ptr]   <= push0_data;
      if (accept1) mem[wr_ptr_b] <= push1_data;
   end

   assign count = cnt;
   assign head  = mem[rd_ptr];

endmodule

// File: rtl/writeback_unit.sv
// Tail-of-pipeline register-file writer: merges ALU (A) and load/FPU (B)
// results onto one write port and scoreboards in-flight destinations.
module writeback_unit
   import constant::*;
#(
   parameter int DEPTH = 4,
   parameter int CNT_W = 2
) (
   input  logic        clk,
   input  logic        rstn,
   input  logic        iss_valid,
   input  logic [1:0]  iss_rw,
   input  logic [4:0]  iss_rd,
   input  logic        a_valid,
   input  logic [1:0]  a_rw,
   input  logic [4:0]  a_rd,
   input  logic [31:0] a_data,
   input  logic        b_valid,
   input  logic [1:0]  b_rw,
   input  logic [4:0]  b_rd,
   input  logic [31:0] b_data,
   input  logic [5:0]  rs,
   input  logic [5:0]  rt,
   output logic        busy_s,
   output logic        busy_t,
   output logic [1:0]  rw,
   output logic [4:0]  rd,
   output logic [31:0] dtowrite,
   output logic        stall,
   output logic        err
);

   localparam int              PTR_W   = $clog2(DEPTH);
   localparam logic [CNT_W-1:0] CNT_MAX = '1;

   wb_req_t           a_req;
   wb_req_t           b_req;
   wb_req_t           head;
   wb_req_t           sel;
   logic              a_ok;
   logic              b_ok;
   logic              sel_valid;
   logic              pop;
   logic              push0_valid;
   logic              push1_valid;
   logic              fifo_ovf;
   logic [PTR_W:0]    fifo_count;

   logic [CNT_W-1:0]  sb [64];
   logic [5:0]        inc_idx;
   logic [5:0]        dec_idx;
   logic              inc_en;
   logic              dec_en;
   logic              same;
   logic              inc_ovf;
   logic              dec_unf;

   assign a_req = '{rw: a_rw, rd: a_rd, data: a_data};
   assign b_req = '{rw: b_rw, rd: b_rd, data: b_data};
   assign a_ok  = a_valid && (a_rw != RW_NONE);
   assign b_ok  = b_valid && (b_rw != RW_NONE);

   wb_fifo #(.DEPTH(DEPTH)) u_fifo (
      .clk         (clk),
      .rstn        (rstn),
      .push0_valid (push0_valid),
      .push0_data  (b_req),
      .push1_valid (push1_valid),
      .push1_data  (a_req),
      .pop         (pop),
      .count       (fifo_count),
      .head        (head),
      .overflow    (fifo_ovf)
   );

   // Buffered results drain first so older writes never get reordered
   always_comb begin
      sel_valid   = 1'b0;
      sel         = '0;
      pop         = 1'b0;
      push0_valid = 1'b0;
      push1_valid = 1'b0;
      if (fifo_count != '0) begin
         sel_valid   = 1'b1;
         sel         = head;
         pop         = 1'b1;
         push0_valid = b_ok;
         push1_valid = a_ok;
      end else if (b_ok) begin
         sel_valid   = 1'b1;
         sel         = b_req;
         push1_valid = a_ok;
      end else if (a_ok) begin
         sel_valid   = 1'b1;
         sel         = a_req;
      end
   end

   always_ff @(posedge clk or negedge rstn) begin
      if (!rstn) begin
         rw       <= RW_NONE;
         rd       <= '0;
         dtowrite <= '0;
      end else begin
         rw <= sel_valid ? sel.rw : RW_NONE;
         if (sel_valid) begin
            rd       <= sel.rd;
            dtowrite <= sel.data;
         end
      end
   end

   // Slot 0 is GPR r0, which is never tracked in either direction
   always_comb begin
      inc_idx = sb_index(iss_rw, iss_rd);
      dec_idx = sb_index(sel.rw, sel.rd);
      inc_en  = iss_valid && (iss_rw != RW_NONE) && (inc_idx != '0);
      dec_en  = sel_valid && (dec_idx != '0);
      same    = inc_en && dec_en && (inc_idx == dec_idx);
      inc_ovf = inc_en && !same && (sb[inc_idx] == CNT_MAX);
      dec_unf = dec_en && !same && (sb[dec_idx] == '0);
   end

   always_ff @(posedge clk or negedge rstn) begin
      if (!rstn) begin
         for (int i = 0; i < 64; i++) sb[i] <= '0;
      end else begin
         if (inc_en && !same && !inc_ovf) sb[inc_idx] <= sb[inc_idx] + CNT_W'(1);
         if (dec_en && !same && !dec_unf) sb[dec_idx] <= sb[dec_idx] - CNT_W'(1);
      end
   end

   always_ff @(posedge clk or negedge rstn) begin
      if (!rstn) err <= 1'b0;
      else       err <= err | fifo_ovf | inc_ovf | dec_unf;
   end

   assign stall  = fifo_count >= (PTR_W+1)'(DEPTH - 2);
   assign busy_s = sb[rs] != '0;
   assign busy_t = sb[rt] != '0;

endmodule
